univ_shift_reg_n: RTL and testbench

UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

---
 rtl/univ_shift_reg_n.sv | 119 +++++++++++
 tb/tb_univ_shift_reg_n.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register stepped by a debounced push-button or a clean strobe.
// Supports hold, shift, rotate, arithmetic shift and parallel load, and counts executed steps.
module univ_shift_reg_n #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_PERIOD = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_n,
  input  logic [2:0]       mode,
  input  logic             dr,
  input  logic             dl,
  input  logic             cp,
  input  logic             step_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             step_pulse,
  output logic [7:0]       step_cnt
);

  localparam int            CW      = (DEBOUNCE_PERIOD > 1) ? $clog2(DEBOUNCE_PERIOD) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_PERIOD - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASH  = 3'b110;

  logic             sync1_q, sync2_q;
  logic             cp_db_q, cp_db_d;
  logic [CW-1:0]    db_cnt_q, db_cnt_d;
  logic             btn_evt_q, btn_evt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step_pulse_q, step_pulse_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             step;
  logic             op_active;
  logic [WIDTH-1:0] q_next;

  // Debounce: accept a new synchronized level only after it differs for DEBOUNCE_PERIOD cycles.
  always_comb begin
    cp_db_d   = cp_db_q;
    db_cnt_d  = '0;
    btn_evt_d = 1'b0;
    if (sync2_q != cp_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        cp_db_d   = sync2_q;
        btn_evt_d = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign step = btn_evt_q | step_en;

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    q_next    = q_q;
    op_active = 1'b1;
    case (mode)
      MODE_SHR:  q_next = {q_q[WIDTH-2:0], dr};
      MODE_SHL:  q_next = {dl, q_q[WIDTH-1:1]};
      MODE_LOAD: q_next = d;
      MODE_ROR:  q_next = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROL:  q_next = {q_q[0], q_q[WIDTH-1:1]};
      MODE_ASH:  q_next = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      MODE_HOLD: op_active = 1'b0;
      default:   op_active = 1'b0;
    endcase
  end

  // Clear dominates any coincident step, and a button event during clear is simply lost.
  always_comb begin
    q_d          = q_q;
    step_pulse_d = 1'b0;
    step_cnt_d   = step_cnt_q;
    if (!clr_n) begin
      q_d        = '0;
      step_cnt_d = '0;
    end else if (step && op_active) begin
      q_d          = q_next;
      step_pulse_d = 1'b1;
      step_cnt_d   = step_cnt_q + 8'd1;
    end
  end

  // NOTE: reset is asynchronous so outputs clear immediately, independent of clk.
  // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cp_db_q      <= 1'b1;
      db_cnt_q     <= '0;
      btn_evt_q    <= 1'b0;
      q_q          <= '0;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      sync1_q      <= cp;
      sync2_q      <= sync1_q;
      cp_db_q      <= cp_db_d;
      db_cnt_q     <= db_cnt_d;
      btn_evt_q    <= btn_evt_d;
      q_q          <= q_d;
      step_pulse_q <= step_pulse_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign q          = q_q;
  assign step_pulse = step_pulse_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n with WIDTH=4 and a short debounce period.
`timescale 1ns/1ps
module tb_univ_shift_reg_n;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr_n;
  logic [2:0]   mode;
  logic         dr, dl, cp, step_en;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         step_pulse;
  logic [7:0]   step_cnt;

  int checks = 0;
  int errors = 0;
  int pulses;

  univ_shift_reg_n #(.WIDTH(W), .DEBOUNCE_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .clr_n(clr_n), .mode(mode), .dr(dr), .dl(dl),
    .cp(cp), .step_en(step_en), .d(d), .q(q), .step_pulse(step_pulse),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [2:0] m);
    mode    = m;
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_n = 1'b1; mode = 3'b000; dr = 1'b0; dl = 1'b0;
    cp = 1'b1; step_en = 1'b0; d = '0;
    #2;
    check("rst_q", q, 0);
    check("rst_cnt", step_cnt, 0);
    check("rst_pulse", step_pulse, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Parallel load on the first edge after reset release.
    d = 4'b1011;
    do_step(3'b011);
    check("load_q", q, 4'b1011);
    check("load_pulse", step_pulse, 1);
    check("load_cnt", step_cnt, 1);

    // No step: inputs ignored.
    mode = 3'b011; d = 4'b0000; dr = 1'b1;
    tick();
    check("idle_q", q, 4'b1011);
    check("idle_pulse", step_pulse, 0);

    // Shift right (dr enters q[0]).
    dr = 1'b0;
    do_step(3'b001);
    check("shr1_q", q, 4'b0110);
    do_step(3'b001);
    check("shr2_q", q, 4'b1100);
    check("shr2_cnt", step_cnt, 3);
    do_step(3'b100);
    check("ror_q", q, 4'b1001);

    // Shift left (dl enters MSB), rotate left.
    dl = 1'b1;
    do_step(3'b010);
    check("shl_q", q, 4'b1100);
    do_step(3'b101);
    check("rol_q", q, 4'b0110);
    check("rol_cnt", step_cnt, 6);

    // Arithmetic shift, hold and reserved.
    d = 4'b1000;
    do_step(3'b011);
    do_step(3'b110);
    check("ash_q", q, 4'b1100);
    do_step(3'b000);
    check("hold_q", q, 4'b1100);
    check("hold_pulse", step_pulse, 0);
    do_step(3'b111);
    check("rsv_q", q, 4'b1100);
    check("rsv_pulse", step_pulse, 0);
    check("rsv_cnt", step_cnt, 8);

    // Short cp glitch is rejected.
    mode = 3'b011; d = 4'b0101;
    pulses = 0;
    cp = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); if (step_pulse) pulses++; end
    cp = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (step_pulse) pulses++; end
    check("glitch_pulses", pulses, 0);
    check("glitch_q", q, 4'b1100);

    // Long press: event lands on edge 7 together with step_en -> one operation.
    mode = 3'b001; dr = 1'b1;
    pulses = 0;
    cp = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step_en = (i == 7);
      tick();
      if (step_pulse) pulses++;
    end
    step_en = 1'b0;
    check("press_pulses", pulses, 1);
    check("press_q", q, 4'b1001);
    check("press_cnt", step_cnt, 9);
    cp = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (step_pulse) pulses++; end
    check("release_pulses", pulses, 0);

    // Clear beats a coincident step.
    clr_n = 1'b0; d = 4'b1111;
    do_step(3'b011);
    check("clr_q", q, 0);
    check("clr_cnt", step_cnt, 0);
    check("clr_pulse", step_pulse, 0);
    clr_n = 1'b1;

    // Counter wrap.
    d = 4'b1010;
    for (int i = 0; i < 255; i++) do_step(3'b011);
    check("cnt_255", step_cnt, 255);
    do_step(3'b011);
    check("cnt_wrap", step_cnt, 0);
    do_step(3'b011);
    check("pre_rst_pulse", step_pulse, 1);

    // Async reset mid-cycle clears outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_q", q, 0);
    check("async_cnt", step_cnt, 0);
    check("async_pulse", step_pulse, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during debounce abandons the pending press.
    mode = 3'b001; dr = 1'b1;
    cp = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (step_pulse) pulses++; end
    check("abandon_pulses", pulses, 0);
    tick();
    check("fresh_pulse", step_pulse, 1);
    check("fresh_q", q, 4'b0001);
    cp = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
